// File: rtl/fetch_unit_pkg.sv
// Shared SIMPLE core definitions: opcode field constants, reset PC and HLT decode.
package fetch_unit_pkg;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  localparam logic [1:0] OP_ARITH = 2'b11;
  localparam logic [3:0] FN_HLT   = 4'b1111;

  localparam int OP_HI = 15;
  localparam int OP_LO = 14;
  localparam int FN_HI = 7;
  localparam int FN_LO = 4;

  function automatic logic is_hlt(input logic [15:0] instr);
    return (instr[OP_HI:OP_LO] == OP_ARITH) && (instr[FN_HI:FN_LO] == FN_HLT);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction-memory handshake, decode handshake and branch redirect.
interface fetch_unit_if #(
  parameter int ADDR_W = 16
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_data;

  logic [15:0]       command;
  logic [ADDR_W-1:0] cmd_pc;
  logic              cmd_valid;
  logic              cmd_ready;

  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic              halted;

  modport master (
    output imem_req, imem_addr, command, cmd_pc, cmd_valid, halted,
    input  imem_ack, imem_data, cmd_ready, pc_load, pc_target
  );

  modport slave (
    input  imem_req, imem_addr, command, cmd_pc, cmd_valid, halted,
    output imem_ack, imem_data, cmd_ready, pc_load, pc_target
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per request and buffers it for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FULL,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_pc;
  logic [15:0]       command_q;
  logic [ADDR_W-1:0] cmd_pc_q;
  logic              cmd_valid_q;

  // A redirect during an outstanding request parks the target in pend_pc so that
  // IMEM_ADDR (the PC) stays stable until the abandoned access is acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      pend_pc     <= RESET_PC;
      command_q   <= 16'h0000;
      cmd_pc_q    <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;

        S_FETCH: begin
          if (bus.pc_load) begin
            cmd_valid_q <= 1'b0;
            if (bus.imem_ack) begin
              pc    <= bus.pc_target;
              state <= S_FETCH;
            end else begin
              pend_pc <= bus.pc_target;
              state   <= S_DRAIN;
            end
          end else if (bus.imem_ack) begin
            command_q   <= bus.imem_data;
            cmd_pc_q    <= pc + ADDR_W'(1);
            pc          <= pc + ADDR_W'(1);
            cmd_valid_q <= 1'b1;
            state       <= S_FULL;
          end
        end

        S_FULL: begin
          if (bus.pc_load) begin
            pc          <= bus.pc_target;
            cmd_valid_q <= 1'b0;
            state       <= S_FETCH;
          end else if (bus.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state       <= is_hlt(command_q) ? S_HALT : S_FETCH;
          end
        end

        S_DRAIN: begin
          cmd_valid_q <= 1'b0;
          if (bus.imem_ack) begin
            pc    <= bus.pc_load ? bus.pc_target : pend_pc;
            state <= S_FETCH;
          end else if (bus.pc_load) begin
            pend_pc <= bus.pc_target;
          end
        end

        S_HALT: state <= S_HALT;

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req  = (state == S_FETCH) || (state == S_DRAIN);
  assign bus.imem_addr = pc;
  assign bus.halted    = (state == S_HALT);
  assign bus.command   = command_q;
  assign bus.cmd_pc    = cmd_pc_q;
  assign bus.cmd_valid = cmd_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus randomized ready/redirect/wait traffic.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] pc1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(16)) bus();

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  logic [15:0] next_addr;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          wait_mode = 0;
  bit          hlt_en = 1'b0;
  logic [15:0] hlt_addr = 16'h0005;

  // Program image: unique per address, never a HLT unless explicitly planted.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    if (hlt_en && a == hlt_addr) return 16'hC0F0;
    return {2'b10, a[5:0], a1[7:0]};
  endfunction

  function automatic void refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{cmd: mem_word(next_addr), pc1: next_addr + 16'd1});
      next_addr = next_addr + 16'd1;
    end
  endfunction

  function automatic void expect_stream(input logic [15:0] start);
    exp_q.delete();
    next_addr = start;
    refill();
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input bit rdy, input bit ld, input logic [15:0] tgt);
    bus.cmd_ready = rdy;
    bus.pc_load   = ld;
    bus.pc_target = tgt;
    if (ld) expect_stream(tgt);
    tick();
    bus.pc_load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.pc_load = 1'b0;
    repeat (2) tick();
    expect_stream(16'h0000);
    rst_n = 1'b1;
  endtask

  // Memory responder: a fixed or random number of wait cycles per request.
  initial begin
    bit in_req;
    int wcnt;
    in_req = 1'b0;
    wcnt = 0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (bus.imem_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          wcnt = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        end
        if (wcnt == 0) begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = mem_word(bus.imem_addr);
          in_req = 1'b0;
        end else begin
          bus.imem_ack  = 1'b0;
          bus.imem_data = 16'hDEAD;
          wcnt--;
        end
      end else begin
        bus.imem_ack = 1'b0;
        in_req = 1'b0;
      end
    end
  end

  // Monitor: scores every consumed instruction and checks request address stability.
  initial begin
    logic        pend_req;
    logic [15:0] pend_addr;
    exp_t        e;
    pend_req = 1'b0;
    pend_addr = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_req = 1'b0;
      end else begin
        if (pend_req) begin
          check_output("req_held", bus.imem_req, 1);
          check_output("addr_stable", bus.imem_addr, pend_addr);
        end
        pend_req  = bus.imem_req && !bus.imem_ack;
        pend_addr = bus.imem_addr;
        if (bus.cmd_valid && bus.cmd_ready && !bus.pc_load) begin
          if (exp_q.size() == 0) begin
            check_output("sb_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_output("sb_command", bus.command, e.cmd);
            check_output("sb_cmd_pc", bus.cmd_pc, e.pc1);
            refill();
          end
        end
      end
    end
  end

  initial begin
    int k;
    logic [15:0] held;
    bus.cmd_ready = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_target = 16'h0000;

    // Reset values and zero-wait stream
    wait_mode = 0;
    bus.cmd_ready = 1'b1;
    do_reset();
    check_output("rst_req", bus.imem_req, 0);
    check_output("rst_valid", bus.cmd_valid, 0);
    check_output("rst_command", bus.command, 16'h0000);
    check_output("rst_cmd_pc", bus.cmd_pc, 16'h0000);
    check_output("rst_halted", bus.halted, 0);
    check_output("rst_addr", bus.imem_addr, 16'h0000);
    tick();
    check_output("req_one_cycle", bus.imem_req, 1);
    tick();
    check_output("zw_valid", bus.cmd_valid, 1);
    check_output("zw_command0", bus.command, 16'h8001);
    check_output("zw_cmd_pc0", bus.cmd_pc, 16'h0001);
    tick();
    check_output("zw_req_n2", bus.imem_req, 1);
    check_output("zw_addr_n2", bus.imem_addr, 16'h0001);
    tick();
    check_output("zw_command1", bus.command, 16'h8102);
    check_output("zw_cmd_pc1", bus.cmd_pc, 16'h0002);

    // Three wait cycles with decode stalled
    wait_mode = 3;
    bus.cmd_ready = 1'b0;
    do_reset();
    tick();
    k = 0;
    while (!bus.cmd_valid && k < 20) begin tick(); k++; end
    check_output("wait3_latency", k, 4);
    held = bus.command;
    check_output("wait3_command", held, 16'h8001);
    repeat (4) begin
      check_output("stall_command", bus.command, 16'h8001);
      check_output("stall_valid", bus.cmd_valid, 1);
      check_output("stall_no_req", bus.imem_req, 0);
      check_output("stall_addr", bus.imem_addr, 16'h0001);
      tick();
    end
    bus.cmd_ready = 1'b1;
    tick();
    check_output("post_stall_req", bus.imem_req, 1);
    check_output("post_stall_addr", bus.imem_addr, 16'h0001);

    // Redirect two cycles before a slow ack
    do_reset();
    tick();
    tick();
    apply_stimulus(1'b1, 1'b1, 16'h0040);
    check_output("drain_req", bus.imem_req, 1);
    check_output("drain_addr_hold", bus.imem_addr, 16'h0000);
    tick();
    check_output("drain_ack_addr", bus.imem_addr, 16'h0000);
    check_output("drain_no_valid", bus.cmd_valid, 0);
    tick();
    check_output("redirect_addr", bus.imem_addr, 16'h0040);
    check_output("redirect_req", bus.imem_req, 1);
    check_output("redirect_no_valid", bus.cmd_valid, 0);
    k = 0;
    while (!bus.cmd_valid && k < 20) begin tick(); k++; end
    check_output("redirect_command", bus.command, 16'h8041);
    check_output("redirect_cmd_pc", bus.cmd_pc, 16'h0041);
    repeat (2) tick();

    // Redirect in the ack cycle
    wait_mode = 0;
    do_reset();
    tick();
    apply_stimulus(1'b1, 1'b1, 16'h0123);
    check_output("ack_load_addr", bus.imem_addr, 16'h0123);
    check_output("ack_load_req", bus.imem_req, 1);
    check_output("ack_load_valid", bus.cmd_valid, 0);
    repeat (4) apply_stimulus(1'b1, 1'b0, 16'h0000);

    // Redirect while full with ready high
    do_reset();
    tick();
    tick();
    check_output("full_valid", bus.cmd_valid, 1);
    apply_stimulus(1'b1, 1'b1, 16'h0077);
    check_output("full_load_valid", bus.cmd_valid, 0);
    check_output("full_load_addr", bus.imem_addr, 16'h0077);
    check_output("full_load_req", bus.imem_req, 1);
    repeat (4) apply_stimulus(1'b1, 1'b0, 16'h0000);

    // HLT at address 5
    hlt_en = 1'b1;
    bus.cmd_ready = 1'b1;
    do_reset();
    k = 0;
    while (!bus.halted && k < 40) begin tick(); k++; end
    check_output("halted", bus.halted, 1);
    check_output("halt_addr", bus.imem_addr, 16'h0006);
    repeat (3) begin
      check_output("halt_no_req", bus.imem_req, 0);
      tick();
    end
    bus.pc_load = 1'b1;
    bus.pc_target = 16'h0200;
    tick();
    bus.pc_load = 1'b0;
    tick();
    check_output("halt_ignores_load", bus.halted, 1);
    check_output("halt_load_addr", bus.imem_addr, 16'h0006);
    check_output("halt_load_req", bus.imem_req, 0);
    rst_n = 1'b0;
    #1;
    check_output("halt_cleared", bus.halted, 0);
    hlt_en = 1'b0;

    // Reset asserted during an outstanding request
    wait_mode = 3;
    do_reset();
    tick();
    tick();
    check_output("mid_req_high", bus.imem_req, 1);
    rst_n = 1'b0;
    #1;
    check_output("reset_drops_req", bus.imem_req, 0);

    // PC wrap at 16'hFFFF
    wait_mode = 0;
    do_reset();
    tick();
    apply_stimulus(1'b0, 1'b1, 16'hFFFF);
    k = 0;
    while (!bus.cmd_valid && k < 20) begin tick(); k++; end
    check_output("wrap_command", bus.command, 16'hBF00);
    check_output("wrap_cmd_pc", bus.cmd_pc, 16'h0000);
    check_output("wrap_addr", bus.imem_addr, 16'h0000);
    repeat (4) apply_stimulus(1'b1, 1'b0, 16'h0000);

    // Randomized traffic
    wait_mode = -1;
    do_reset();
    tick();
    for (int i = 0; i < 1500; i++) begin
      apply_stimulus($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 16'($urandom));
    end
    repeat (10) apply_stimulus(1'b1, 1'b0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the SIMPLE 16-bit core, directly upstream of the decode unit. Holds the program counter, fetches one 16-bit instruction per request over a variable-latency instruction-memory handshake, and presents it on COMMAND with a valid/ready handshake. Accepts PC loads from the branch logic, flushing any buffered or in-flight instruction, and stops fetching after a HLT instruction is delivered.

## Interface
- ADDR_W, 16: instruction address width; the address is word-addressed.
- RESET_PC, 16'h0000: PC value after reset.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IMEM_REQ  out  1  fetch request; IMEM_ADDR is held stable while it is high.
- IMEM_ADDR  out  ADDR_W  fetch address, equal to the PC register.
- IMEM_ACK  in  1  memory returns IMEM_DATA this cycle; may be high in the first cycle of IMEM_REQ.
- IMEM_DATA  in  16  instruction word, valid only when IMEM_ACK is high.
- COMMAND  out  16  buffered instruction for decode.
- CMD_PC  out  ADDR_W  address of COMMAND plus 1.
- CMD_VALID  out  1  COMMAND and CMD_PC are valid.
- CMD_READY  in  1  the downstream stage consumes COMMAND when this and CMD_VALID are both high.
- PC_LOAD  in  1  single-cycle branch-taken pulse.
- PC_TARGET  in  ADDR_W  new PC, sampled when PC_LOAD is high.
- HALTED  out  1  fetch stopped after a HLT was consumed.

## Operation
- States:
  - IDLE: the reset state.
  - FETCH: IMEM_REQ=1.
  - FULL: instruction buffered, no request outstanding.
  - DRAIN: IMEM_REQ=1, returned data is discarded.
  - HALT.
- IMEM_REQ is 1 only in FETCH and DRAIN.
- IDLE -> FETCH unconditionally, one cycle after RST_N deasserts.
- FETCH with IMEM_ACK, no PC_LOAD:
  - COMMAND <= IMEM_DATA, CMD_PC <= PC+1, PC <= PC+1, CMD_VALID <= 1.
  - Next state is FULL.
- FULL, CMD_READY high:
  - CMD_VALID <= 0.
  - If the consumed COMMAND is HLT, next state is HALT; otherwise FETCH.
- FULL, CMD_READY low: hold COMMAND, CMD_PC and CMD_VALID unchanged.
- HLT detection: COMMAND[15:14]==2'b11 and COMMAND[7:4]==4'b1111. A HLT instruction is delivered to decode like any other instruction.
- PC_LOAD has priority over every other event in every state except IDLE and HALT. On PC_LOAD:
  - PC <= PC_TARGET and CMD_VALID <= 0. A simultaneous CMD_READY does not count as a consumption.
  - FETCH without IMEM_ACK -> DRAIN. The address must stay stable, so the outstanding request is completed and then discarded.
  - FETCH with IMEM_ACK: data discarded, PC is not incremented -> FETCH at PC_TARGET.
  - FULL -> FETCH at PC_TARGET. A buffered HLT is cancelled.
  - DRAIN -> remains DRAIN with the new target.
- DRAIN with IMEM_ACK: data dropped, PC unchanged -> FETCH. IMEM_ADDR drops to the new PC only after the ACK cycle.
- HALT is left only by reset. PC_LOAD is ignored in HALT and in IDLE. HALTED=1 only in HALT.
- PC arithmetic is ADDR_W-bit modulo: PC 16'hFFFF increments to 16'h0000, and CMD_PC for that instruction is 16'h0000.

## Timing
- Reset values: state IDLE, PC=RESET_PC, COMMAND=16'h0000, CMD_PC=0, CMD_VALID=0, IMEM_REQ=0, HALTED=0.
- Reset asserted mid-request drops IMEM_REQ immediately. The memory must tolerate an abandoned request.
- Latency with a zero-wait memory (IMEM_ACK in the request cycle):
  - IMEM_REQ in cycle n, CMD_VALID in cycle n+1.
  - With CMD_READY held high, the next IMEM_REQ is in cycle n+2, so peak throughput is one instruction per 2 cycles.
- With k wait cycles, CMD_VALID rises k+1 cycles after IMEM_REQ first rises.
- After PC_LOAD in cycle t in FULL or FETCH+ACK, IMEM_ADDR=PC_TARGET with IMEM_REQ=1 in cycle t+1.
- COMMAND, CMD_PC and CMD_VALID are registered outputs. IMEM_REQ is decoded from state only. IMEM_ADDR is the PC register. No combinational path from any input to any output.

## Structure
- Shared include simple_defs.vh, also used by decode, holds:
  - Opcode field constants: OP_ARITH=2'b11, FN_HLT=4'b1111, field bit positions.
  - RESET_PC default.
- Fetch state encodings are local parameters of fetch_unit.
- Single module, no sub-modules. The PC is one register with mux inputs hold / +1 / PC_TARGET.

## Test plan
- Reset release, zero-wait memory returning 16'h8001 at address 0 and 16'h8102 at address 1:
  - IMEM_REQ rises one cycle after reset; COMMAND=16'h8001 with CMD_PC=1, then COMMAND=16'h8102 with CMD_PC=2.
- Memory with 3 wait cycles, CMD_READY held low for 4 cycles after CMD_VALID:
  - COMMAND is stable throughout, no new IMEM_REQ is issued, and there is no PC advance until consumption.
- PC_LOAD with PC_TARGET=16'h0040 while in FETCH, two cycles before IMEM_ACK:
  - Returned data is never presented and CMD_VALID stays 0.
  - The next request is to address 0x0040; the instruction delivered carries CMD_PC=0x0041.
- PC_LOAD in the same cycle as IMEM_ACK, and separately in FULL with CMD_READY=1: no instruction is delivered from the old stream.
- Memory returns HLT 16'hC0F0 at address 5:
  - Delivered with CMD_PC=6, then HALTED=1 and IMEM_REQ stays 0.
  - A later PC_LOAD is ignored; reset clears HALTED.
- PC=16'hFFFF fetch: CMD_PC=16'h0000 and the next IMEM_ADDR=16'h0000.
